// File: rtl/phase_accumulator_pkg.sv
// Shared constants for the sliced DDS phase accumulator.
// Slice width, slice count, phase width and pipeline latency live here.
package phase_accumulator_pkg;

  localparam int unsigned DDSM_SLICE_W = 8;
  localparam int unsigned DDSM_SLICES  = 3;
  localparam int unsigned DDSM_PHASE_W = DDSM_SLICE_W * DDSM_SLICES;
  localparam int unsigned DDSM_LAT     = DDSM_SLICES;

  typedef logic [DDSM_PHASE_W-1:0] phase_t;

endpackage

// File: rtl/phase_acc_slice.sv
// One slice of the phase accumulator: a registered accumulator with carry-in,
// enable and synchronous clear, plus a registered carry-out.
module phase_acc_slice
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned P_W = DDSM_SLICE_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_clear,
  input  logic [P_W-1:0] i_addend,
  input  logic           i_carry,
  output logic [P_W-1:0] o_acc,
  output logic           o_carry
);

  logic [P_W-1:0] acc_q, acc_d;
  logic           carry_q, carry_d;
  logic [P_W:0]   sum;

  // The carry register only holds a carry for the step just taken, so the
  // downstream slice never sees a stale carry from an earlier step.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, i_addend} + {{P_W{1'b0}}, i_carry};
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (i_clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (i_en) begin
      acc_d   = sum[P_W-1:0];
      carry_d = sum[P_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign o_acc   = acc_q;
  assign o_carry = carry_q;

endmodule

// File: rtl/phase_accumulator.sv
// 24-bit DDS phase accumulator split into three carry-pipelined 8-bit slices,
// with input skew and output deskew so every output word is one coherent phase.
module phase_accumulator
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned P_SLICE_W = DDSM_SLICE_W,
  parameter int unsigned P_LAT     = DDSM_LAT
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en,
  input  logic                               i_clear,
  input  logic                               i_fcw_load,
  input  logic [DDSM_SLICES*P_SLICE_W-1:0]   i_fcw,
  output logic [P_SLICE_W-1:0]               o_msb,
  output logic [P_SLICE_W-1:0]               o_isb,
  output logic [P_SLICE_W-1:0]               o_lsb,
  output logic                               o_valid,
  output logic                               o_wrap
);

  localparam int unsigned W = P_SLICE_W;

  logic [DDSM_SLICES*W-1:0] fcw_q, fcw_d;
  logic [P_LAT-1:0]         en_q, en_d;
  logic [W-1:0]             fcw_isb1_q, fcw_isb1_d;
  logic [W-1:0]             fcw_msb1_q, fcw_msb1_d;
  logic [W-1:0]             fcw_msb2_q, fcw_msb2_d;
  logic [W-1:0]             lsb_dly1_q, lsb_dly1_d;
  logic [W-1:0]             lsb_dly2_q, lsb_dly2_d;
  logic [W-1:0]             isb_dly1_q, isb_dly1_d;

  logic [W-1:0] lsb_acc, isb_acc, msb_acc;
  logic         lsb_cy, isb_cy, msb_cy;

  // FCW register is untouched by clear; a step on the load edge uses the old word.
  always_comb begin
    fcw_d = fcw_q;
    if (i_fcw_load) fcw_d = i_fcw;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fcw_q <= '0;
    else          fcw_q <= fcw_d;
  end

  // Skew and deskew run every edge; the FCW upper slices travel with the enable.
  always_comb begin
    en_d        = {en_q[P_LAT-2:0], i_en};
    fcw_isb1_d  = fcw_q[2*W-1:W];
    fcw_msb1_d  = fcw_q[3*W-1:2*W];
    fcw_msb2_d  = fcw_msb1_q;
    lsb_dly1_d  = lsb_acc;
    lsb_dly2_d  = lsb_dly1_q;
    isb_dly1_d  = isb_acc;
    if (i_clear) begin
      en_d       = '0;
      fcw_isb1_d = '0;
      fcw_msb1_d = '0;
      fcw_msb2_d = '0;
      lsb_dly1_d = '0;
      lsb_dly2_d = '0;
      isb_dly1_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q       <= '0;
      fcw_isb1_q <= '0;
      fcw_msb1_q <= '0;
      fcw_msb2_q <= '0;
      lsb_dly1_q <= '0;
      lsb_dly2_q <= '0;
      isb_dly1_q <= '0;
    end else begin
      en_q       <= en_d;
      fcw_isb1_q <= fcw_isb1_d;
      fcw_msb1_q <= fcw_msb1_d;
      fcw_msb2_q <= fcw_msb2_d;
      lsb_dly1_q <= lsb_dly1_d;
      lsb_dly2_q <= lsb_dly2_d;
      isb_dly1_q <= isb_dly1_d;
    end
  end

  phase_acc_slice #(.P_W(W)) u_lsb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_en),
    .i_clear  (i_clear),
    .i_addend (fcw_q[W-1:0]),
    .i_carry  (1'b0),
    .o_acc    (lsb_acc),
    .o_carry  (lsb_cy)
  );

  phase_acc_slice #(.P_W(W)) u_isb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (en_q[0]),
    .i_clear  (i_clear),
    .i_addend (fcw_isb1_q),
    .i_carry  (lsb_cy),
    .o_acc    (isb_acc),
    .o_carry  (isb_cy)
  );

  phase_acc_slice #(.P_W(W)) u_msb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (en_q[1]),
    .i_clear  (i_clear),
    .i_addend (fcw_msb2_q),
    .i_carry  (isb_cy),
    .o_acc    (msb_acc),
    .o_carry  (msb_cy)
  );

  assign o_msb   = msb_acc;
  assign o_isb   = isb_dly1_q;
  assign o_lsb   = lsb_dly2_q;
  assign o_valid = en_q[P_LAT-1];
  assign o_wrap  = msb_cy & en_q[P_LAT-1];

endmodule

// File: tb/tb_phase_accumulator.sv
// Bench for phase_accumulator: a step-level reference model checked every cycle,
// plus hand-computed literal checkpoints on directed vectors.
module tb_phase_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_en, i_clear, i_fcw_load;
  logic [23:0] i_fcw;
  logic [7:0]  o_msb, o_isb, o_lsb;
  logic        o_valid, o_wrap;

  int n_vec = 0;
  int n_err = 0;

  phase_accumulator #(.P_SLICE_W(8), .P_LAT(3)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_clear    (i_clear),
    .i_fcw_load (i_fcw_load),
    .i_fcw      (i_fcw),
    .o_msb      (o_msb),
    .o_isb      (o_isb),
    .o_lsb      (o_lsb),
    .o_valid    (o_valid),
    .o_wrap     (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: each accepted step yields a result due two edges later.
  typedef struct {
    int unsigned due;
    logic [23:0] val;
    logic        wrap;
  } pend_t;

  pend_t       pq[$];
  int unsigned k = 0;
  logic [23:0] m_p = '0, m_fcw = '0, m_disp = '0;
  logic        m_valid = 1'b0, m_wrap = 1'b0;
  logic [24:0] sum;

  always @(posedge i_clk) begin
    k++;
    m_valid = 1'b0;
    m_wrap  = 1'b0;
    if (!i_rst_n) begin
      m_p = '0; m_fcw = '0; m_disp = '0; pq.delete();
    end else begin
      if (i_clear) begin
        m_p = '0; m_disp = '0; pq.delete();
      end else begin
        if (pq.size() > 0 && pq[0].due == k) begin
          m_disp  = pq[0].val;
          m_valid = 1'b1;
          m_wrap  = pq[0].wrap;
          void'(pq.pop_front());
        end
        if (i_en) begin
          sum = {1'b0, m_p} + {1'b0, m_fcw};
          m_p = sum[23:0];
          pq.push_back('{due: k + 2, val: sum[23:0], wrap: sum[24]});
        end
      end
      if (i_fcw_load) m_fcw = i_fcw;
    end
    #1;
    n_vec++;
    if ({o_msb, o_isb, o_lsb} !== m_disp || o_valid !== m_valid || o_wrap !== m_wrap) begin
      n_err++;
      $display("FAIL model@edge%0d: got word=%06h valid=%b wrap=%b, expected word=%06h valid=%b wrap=%b",
               k, {o_msb, o_isb, o_lsb}, o_valid, o_wrap, m_disp, m_valid, m_wrap);
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check_lit(input string name, input logic [23:0] w, input logic v, input logic wr);
    n_vec++;
    if ({o_msb, o_isb, o_lsb} !== w || o_valid !== v || o_wrap !== wr) begin
      n_err++;
      $display("FAIL %s: got word=%06h valid=%b wrap=%b, expected word=%06h valid=%b wrap=%b",
               name, {o_msb, o_isb, o_lsb}, o_valid, o_wrap, w, v, wr);
    end
  endtask

  task automatic load(input logic [23:0] v);
    i_fcw_load = 1'b1;
    i_fcw      = v;
    tick();
    i_fcw_load = 1'b0;
  endtask

  task automatic clr();
    i_clear = 1'b1;
    tick();
    check_lit("clear", 24'h000000, 1'b0, 1'b0);
    i_clear = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b1; i_en = 1'b0; i_clear = 1'b0; i_fcw_load = 1'b0; i_fcw = '0;
    #1 i_rst_n = 1'b0;
    #1 check_lit("reset_hold", 24'h000000, 1'b0, 1'b0);
    tick(); tick();
    i_rst_n = 1'b1;

    // FCW = 1: ramp, and the isb carry after 256 steps
    load(24'h000001);
    i_en = 1'b1;
    tick(); tick(); tick();
    check_lit("fcw1_first", 24'h000001, 1'b1, 1'b0);
    repeat (253) tick();
    i_en = 1'b0;
    tick(); tick();
    check_lit("fcw1_256", 24'h000100, 1'b1, 1'b0);
    tick();
    check_lit("fcw1_hold", 24'h000100, 1'b0, 1'b0);

    // FCW = 0xFFFFFF: descending, wrap from the second output
    clr();
    load(24'hFFFFFF);
    i_en = 1'b1;
    tick(); tick(); tick();
    check_lit("ffffff_1", 24'hFFFFFF, 1'b1, 1'b0);
    tick();
    check_lit("ffffff_2", 24'hFFFFFE, 1'b1, 1'b1);
    tick();
    check_lit("ffffff_3", 24'hFFFFFD, 1'b1, 1'b1);
    i_en = 1'b0;
    repeat (3) tick();

    // FCW = 0x800000: msb alternates, wrap on every zero
    clr();
    load(24'h800000);
    i_en = 1'b1;
    tick(); tick(); tick();
    check_lit("half_1", 24'h800000, 1'b1, 1'b0);
    tick();
    check_lit("half_2", 24'h000000, 1'b1, 1'b1);
    tick();
    check_lit("half_3", 24'h800000, 1'b1, 1'b0);
    tick();
    check_lit("half_4", 24'h000000, 1'b1, 1'b1);
    i_en = 1'b0;
    repeat (3) tick();

    // FCW change under continuous enable; load edge still uses the old word
    clr();
    load(24'h0000FF);
    i_en = 1'b1;
    repeat (4) tick();
    i_fcw_load = 1'b1;
    i_fcw      = 24'h010000;
    tick();
    i_fcw_load = 1'b0;
    tick(); tick();
    i_en = 1'b0;
    tick(); tick();
    check_lit("fcw_change", 24'h0204FB, 1'b1, 1'b0);

    // 5-cycle enable gap
    i_en = 1'b1;
    repeat (3) tick();
    i_en = 1'b0;
    repeat (5) tick();
    i_en = 1'b1;
    repeat (3) tick();
    i_en = 1'b0;
    tick(); tick();
    check_lit("after_gap", 24'h0804FB, 1'b1, 1'b0);
    tick();

    // clear with enable high, restart, then asynchronous reset mid-run
    i_en = 1'b1;
    tick(); tick();
    i_clear = 1'b1;
    tick();
    check_lit("clear_mid", 24'h000000, 1'b0, 1'b0);
    i_clear = 1'b0;
    tick(); tick(); tick();
    check_lit("clear_restart", 24'h010000, 1'b1, 1'b0);
    tick(); tick();
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_lit("reset_mid", 24'h000000, 1'b0, 1'b0);
    i_en = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    load(24'h000005);
    i_en = 1'b1;
    tick(); tick(); tick();
    check_lit("reset_restart", 24'h000005, 1'b1, 1'b0);
    tick();
    check_lit("reset_restart2", 24'h00000A, 1'b1, 1'b0);
    i_en = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
